extend_pipe: RTL and testbench
==============================

EXTEND_PIPE -- requirements
Module: extend_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values are 16, 32 and 64.
REQ-002 SHALL have localparam HALF_W = DATA_W/2 and localparam AL_W = $clog2(DATA_W/8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  source presents an operation.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 in_data  input  DATA_W  raw operand, e.g. immediate or memory word.
REQ-008 in_size  input  2  field size: 00 byte, 01 half (HALF_W), 10 word, 11 reserved.
REQ-009 in_mode  input  2  extension mode: 00 zero-extend, 01 sign-extend, 10 shift-left-half, 11 sign-extend then shift-left-2.
REQ-010 in_addr  input  AL_W  byte lane of the field; ignored unless EXT_ALIGN_EN is defined.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  sink accepts the result.
REQ-013 out_data  output  DATA_W  extended result.
REQ-014 out_err  output  1  operation was illegal; qualified by out_valid.

Function
REQ-015 An operation SHALL be accepted on a clk edge where in_valid and in_ready are both 1; a result SHALL be consumed on an edge where out_valid and out_ready are both 1.
REQ-016 Buffering SHALL be a 2-entry in-order FIFO with occupancy count 0..2: in_ready = (count<2); out_valid = (count>0).
REQ-017 Latency SHALL be exactly one cycle: an operation accepted at edge N appears on out_data at edge N+1 if the FIFO was empty.
REQ-018 With out_ready held at 1, the block SHALL sustain one operation per cycle.
REQ-019 Simultaneous accept and consume SHALL leave count unchanged; at count 2 no accept can occur.
REQ-020 The field SHALL be the low 8, HALF_W or DATA_W bits of in_data for size byte, half and word.
REQ-021 Mode 00 SHALL zero-fill the field to DATA_W; mode 01 SHALL replicate the field MSB.
REQ-022 Mode 10 SHALL output {in_data[HALF_W-1:0], HALF_W zeros}, independent of in_size (LUI form).
REQ-023 Mode 11 SHALL output the sign-extended field shifted left by 2, dropping the top 2 bits (branch offset).
REQ-024 in_size 11 SHALL set out_err=1 and out_data=0 for that entry.
REQ-025 out_data and out_err SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 The result SHALL be computed at accept and stored in the FIFO; outputs SHALL be driven from the head entry.

Reset
REQ-027 While reset=1 on an edge: count=0, out_valid=0, out_data=0, out_err=0; in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL discard all buffered entries; any handshake in the reset cycle SHALL be ignored.

Configuration
REQ-029 When macro EXT_ALIGN_EN is defined, the field SHALL be taken from in_data >> (8*in_addr).
REQ-030 Under EXT_ALIGN_EN, half with in_addr[0]=1 or word with in_addr!=0 SHALL set out_err=1 and out_data=0.
REQ-031 Without EXT_ALIGN_EN, in_addr SHALL be unused and SHALL never cause out_err.

Structure
REQ-032 Package ext_pkg SHALL hold the size and mode enumerations (SZ_BYTE, SZ_HALF, SZ_WORD, MD_ZERO, MD_SIGN, MD_SHLH, MD_SHL2).
REQ-033 Combinational extension SHALL live in one sub-module, ext_core (field select, extend, shift, error); extend_pipe SHALL hold the FIFO and handshake.

Verification
REQ-034 Half/sign case: in_data=0x0000AD6A, size 01, mode 01 -> out_data=0xFFFFAD6A one cycle later; 0x00002D6A -> 0x00002D6A.
REQ-035 Zero extend and LUI: 0x0000ED6A, mode 00 -> 0x0000ED6A; 0x00001234, mode 10 -> 0x12340000; 0x0000FFFE, mode 11 -> 0xFFFFFFF8.
REQ-036 Backpressure: out_ready=0 while issuing 3 back-to-back operations -> 2 accepted, in_ready=0, third held; raising out_ready drains results in order.
REQ-037 Throughput and reset: stream 8 operations with out_ready=1 -> 8 results on consecutive cycles; reset with 2 buffered -> out_valid=0 next cycle, no stale data.
REQ-038 Alignment (EXT_ALIGN_EN): in_data=0x00AB0000, byte, sign, in_addr=2 -> 0xFFFFFFAB; half with in_addr=1 -> out_err=1, out_data=0; size 11 -> out_err=1 in both builds.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared encodings for the operand-extension pipeline: field sizes and extension modes.
package ext_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        MD_ZERO = 2'b00,
        MD_SIGN = 2'b01,
        MD_SHLH = 2'b10,
        MD_SHL2 = 2'b11
    } mode_e;

endpackage

// File: rtl/ext_core.sv
// Combinational field select, zero/sign extension, shift forms and error detection.
// Lane-aligned field extraction is enabled with macro EXT_ALIGN_EN.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int HALF_W = DATA_W / 2,
    parameter int AL_W   = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic [1:0]        mode,
    input  logic [AL_W-1:0]   addr,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic              misalign;

`ifdef EXT_ALIGN_EN
    assign src      = data >> {addr, 3'b000};
    assign misalign = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr != '0));
`else
    logic unused_addr;
    assign unused_addr = ^addr;
    assign src         = data;
    assign misalign    = 1'b0;
`endif

    always_comb begin
        zext = src;
        sext = src;
        case (size)
            SZ_BYTE: begin
                zext = {{(DATA_W-8){1'b0}}, src[7:0]};
                sext = {{(DATA_W-8){src[7]}}, src[7:0]};
            end
            SZ_HALF: begin
                zext = {{(DATA_W-HALF_W){1'b0}}, src[HALF_W-1:0]};
                sext = {{(DATA_W-HALF_W){src[HALF_W-1]}}, src[HALF_W-1:0]};
            end
            default: ;
        endcase
    end

    // LUI form always takes the raw low half, regardless of size or lane.
    always_comb begin
        result = '0;
        err    = (size == SZ_RSVD) || misalign;
        case (mode)
            MD_ZERO: result = zext;
            MD_SIGN: result = sext;
            MD_SHLH: result = {data[HALF_W-1:0], {HALF_W{1'b0}}};
            default: result = {sext[DATA_W-3:0], 2'b00};
        endcase
        if (err) result = '0;
    end

endmodule

// File: rtl/extend_pipe.sv
// Operand-extension pipeline: valid/ready handshake around a 2-entry in-order FIFO
// holding results computed by ext_core at accept time. Optional macro: EXT_ALIGN_EN.
module extend_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [1:0]                      in_size,
    input  logic [1:0]                      in_mode,
    input  logic [$clog2(DATA_W/8)-1:0]     in_addr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_err
);

    localparam int HALF_W = DATA_W / 2;
    localparam int AL_W   = $clog2(DATA_W / 8);

    logic [DATA_W-1:0] core_result;
    logic              core_err;
    logic [DATA_W-1:0] mem_data [2];
    logic              mem_err  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    ext_core #(
        .DATA_W (DATA_W),
        .HALF_W (HALF_W),
        .AL_W   (AL_W)
    ) u_core (
        .data   (in_data),
        .size   (in_size),
        .mode   (in_mode),
        .addr   (in_addr),
        .result (core_result),
        .err    (core_err)
    );

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_data[rd_ptr];
    assign out_err   = mem_err[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= core_result;
                mem_err[wr_ptr]  <= core_err;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench for extend_pipe: driver pushes model results, a negedge monitor pops and compares.
module tb_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic [1:0]  in_mode;
    logic [1:0]  in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    always #5 clk = ~clk;

    extend_pipe #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_size   (in_size),
        .in_mode   (in_mode),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    logic        hold_v   = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;

    // Reference: field value as an integer, two's-complement reinterpretation, then arithmetic shifts.
    function automatic exp_t model(input logic [31:0] data, input logic [1:0] size,
                                   input logic [1:0] mode, input logic [1:0] addr);
        exp_t            e;
        longint unsigned src;
        longint unsigned w;
        longint unsigned field;
        longint          sf;
        src   = data;
        e.err = (size == 2'd3);
`ifdef EXT_ALIGN_EN
        src = data >> (8 * addr);
        if ((size == 2'd1 && (addr % 2) == 1) || (size == 2'd2 && addr != 0)) e.err = 1'b1;
`endif
        w     = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        field = src % (64'd1 << w);
        if (field >= (64'd1 << (w - 1))) sf = longint'(field) - longint'(64'd1 << w);
        else                             sf = longint'(field);
        case (mode)
            2'd0:    e.data = 32'(field);
            2'd1:    e.data = 32'(sf);
            2'd2:    e.data = 32'(longint'(data % 32'd65536) * 65536);
            default: e.data = 32'(sf * 4);
        endcase
        if (e.err) e.data = 32'd0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_data", out_data, hold_d);
                check("hold_err", {31'd0, out_err}, {31'd0, hold_e});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h with no expected entry", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_err", {31'd0, out_err}, {31'd0, e.err});
                end
                pops++;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_e = out_err;
        end
    end

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] s,
                         input logic [1:0] m, input logic [1:0] a, output logic acc);
        in_valid = v;
        in_data  = d;
        in_size  = s;
        in_mode  = m;
        in_addr  = a;
        @(negedge clk);
        #1;
        acc = v && in_ready && !reset;
        if (acc) q.push_back(model(d, s, m, a));
        @(posedge clk);
        #1;
    endtask

    task automatic known(input string nm, input logic [31:0] d, input logic [1:0] s,
                         input logic [1:0] m, input logic [1:0] a,
                         input logic [31:0] ed, input logic ee);
        logic acc;
        out_ready = 1'b1;
        drive(1'b1, d, s, m, a, acc);
        check({nm, "_acc"}, {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({nm, "_data"}, out_data, ed);
        check({nm, "_err"}, {31'd0, out_err}, {31'd0, ee});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   nacc;
        int   p0;
        int   k;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = '0;
        in_mode   = '0;
        in_addr   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        known("half_sign_neg", 32'h0000AD6A, 2'd1, 2'd1, 2'd0, 32'hFFFFAD6A, 1'b0);
        known("half_sign_pos", 32'h00002D6A, 2'd1, 2'd1, 2'd0, 32'h00002D6A, 1'b0);
        known("half_zero",     32'h0000ED6A, 2'd1, 2'd0, 2'd0, 32'h0000ED6A, 1'b0);
        known("lui",           32'h00001234, 2'd1, 2'd2, 2'd0, 32'h12340000, 1'b0);
        known("shl2",          32'h0000FFFE, 2'd1, 2'd3, 2'd0, 32'hFFFFFFF8, 1'b0);
        known("byte_sign",     32'h12345680, 2'd0, 2'd1, 2'd0, 32'hFFFFFF80, 1'b0);
        known("size_rsvd",     32'hDEADBEEF, 2'd3, 2'd0, 2'd0, 32'h00000000, 1'b1);
`ifdef EXT_ALIGN_EN
        known("align_byte",    32'h00AB0000, 2'd0, 2'd1, 2'd2, 32'hFFFFFFAB, 1'b0);
        known("align_half_bad", 32'h00AB0000, 2'd1, 2'd1, 2'd1, 32'h00000000, 1'b1);
`else
        known("noalign_addr",  32'h00AB0080, 2'd0, 2'd1, 2'd2, 32'hFFFFFF80, 1'b0);
        known("noalign_word",  32'h89ABCDEF, 2'd2, 2'd0, 2'd3, 32'h89ABCDEF, 1'b0);
`endif

        // Backpressure: two fill the FIFO, the third must wait.
        out_ready = 1'b0;
        nacc = 0;
        drive(1'b1, 32'h000000F1, 2'd0, 2'd1, 2'd0, acc); nacc += int'(acc);
        drive(1'b1, 32'h00008002, 2'd1, 2'd0, 2'd0, acc); nacc += int'(acc);
        drive(1'b1, 32'h00000073, 2'd0, 2'd3, 2'd0, acc); nacc += int'(acc);
        check("bp_accepted", nacc, 2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 6) begin
            drive(1'b1, 32'h00000073, 2'd0, 2'd3, 2'd0, acc);
            k++;
        end
        check("bp_third_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, '0, acc);
        check("bp_drained", q.size(), 0);

        // Throughput: eight back-to-back operations retire on eight consecutive cycles.
        p0   = pops;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), acc);
            nacc += int'(acc);
        end
        drive(1'b0, '0, '0, '0, '0, acc);
        check("tp_accepted", nacc, 8);
        check("tp_results", pops - p0, 8);

        // Reset with two entries buffered discards them; handshake in the reset cycle is ignored.
        out_ready = 1'b0;
        drive(1'b1, 32'h000000AA, 2'd0, 2'd1, 2'd0, acc);
        drive(1'b1, 32'h000000BB, 2'd0, 2'd1, 2'd0, acc);
        check("rst2_buffered", {31'd0, in_ready}, 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        q.delete();
        drive(1'b1, 32'h000000CC, 2'd0, 2'd1, 2'd0, acc);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_data", out_data, 32'd0);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 2) != 0), $urandom, 2'($urandom), 2'($urandom),
                  2'($urandom), acc);
        end
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 10) begin
            drive(1'b0, '0, '0, '0, '0, acc);
            k++;
        end
        check("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
